dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between NUM_PORTS requesters (port 0 = core
//  load/store unit, port 1 = DMA/debug loader). Accepts one request per access via
//  a valid/ready handshake and drives the memory's wr_en/addr/wr_data pins. Samples
//  the memory's combinational read data and returns it as a one-cycle response pulse.
//  Sits between the requesters and dmem; dmem's own flop reset is untouched.
// PARAMETERS
//  NUM_PORTS   2                        requesters, >=2
//  ADDR_WIDTH  params_pkg::ADDR_WIDTH   memory address width
//  DATA_WIDTH  params_pkg::DATA_WIDTH   memory data width
//  MEM_SIZE    params_pkg::MEM_SIZE     valid words; addr >= MEM_SIZE is an error
// PORTS
//  clk_i          in   1                       clock, rising edge
//  rst_i          in   1                       reset, asynchronous, active-low
//  req_valid_i    in   NUM_PORTS               per-port request valid
//  req_ready_o    out  NUM_PORTS               per-port request accepted (one-hot or 0)
//  req_we_i       in   NUM_PORTS               1 = write, 0 = read
//  req_addr_i     in   NUM_PORTS x ADDR_WIDTH  per-port address
//  req_wdata_i    in   NUM_PORTS x DATA_WIDTH  per-port write data
//  rsp_valid_o    out  NUM_PORTS               one-cycle completion pulse to owner port
//  rsp_rdata_o    out  DATA_WIDTH              read data (0 for writes/errors)
//  rsp_err_o      out  1                       out-of-range, qualified by rsp_valid_o
//  mem_wr_en_o    out  1                       to dmem wr_en_i
//  mem_addr_o     out  ADDR_WIDTH              to dmem addr_i
//  mem_wr_data_o  out  DATA_WIDTH              to dmem wr_data_i
//  mem_rd_data_i  in   DATA_WIDTH              from dmem rd_data_o (combinational)
// BEHAVIOUR
//  - FSM IDLE -> ACCESS -> RESP -> IDLE; reset state IDLE.
//  - IDLE: winner chosen combinationally among req_valid_i; req_ready_o[winner]=1,
//    others 0. Handshake = valid & ready. On handshake register we/addr/wdata/port
//    into *_q, go to ACCESS. No valid -> stay IDLE, all ready 0.
//  - ACCESS: mem_addr_o=addr_q; mem_wr_data_o=wdata_q; mem_wr_en_o=we_q & in-range.
//    Capture rdata_q = (!we_q & in-range) ? mem_rd_data_i : 0; err_q = !in-range. -> RESP.
//  - RESP: rsp_valid_o[port_q]=1 exactly one cycle, rsp_rdata_o=rdata_q,
//    rsp_err_o=err_q. -> IDLE. No response back-pressure.
//  - Latency: handshake cycle N, memory cycle N+1 (write commits at end of N+1),
//    response cycle N+2; earliest next accept N+3. Throughput 1 access / 3 cycles.
//  - req_ready_o is 0 in ACCESS and RESP; pending valids must be held.
//  - Outside ACCESS: mem_wr_en_o=0, mem_addr_o/mem_wr_data_o hold *_q values.
//  - Round-robin: last_q = port of last grant; search starts at (last_q+1) mod
//    NUM_PORTS, wrapping; last_q updates on handshake only.
//  - In-range: addr_q < MEM_SIZE (compare at ADDR_WIDTH+1 bits; no wrap).
//    Out-of-range write: no memory write, rsp_err_o=1, rsp_rdata_o=0.
//  - Reset (any cycle, incl. mid-ACCESS/RESP): async clear to IDLE; last_q=NUM_PORTS-1
//    (port 0 wins first); all *_q=0; all outputs 0; in-flight request dropped, no rsp.
//    A write in ACCESS when reset asserts must not commit (mem_wr_en_o drops at once).
// CONFIGURATION
//  DMEM_ARBITER_FIXED_PRIO_EN
//   defined:   fixed priority, lowest-index valid port wins; last_q unused.
//   undefined: round-robin as above (default).
// TESTING
//  1 Reset: rst_i=0 mid-ACCESS of write addr 5 -> mem_wr_en_o=0 immediately,
//    all outputs 0, no rsp_valid_o; after release port 0 wins first tie.
//  2 P0 write addr 3 data 0xAB, then P0 read addr 3 -> rsp_valid_o[0] at N+2
//    each; read rsp_rdata_o=0xAB, rsp_err_o=0.
//  3 Both ports valid continuously (reads addr 1/2) -> grants 0,1,0,1; one per
//    3 cycles; P1 rdata = dmem contents at 2.
//  4 Same with DMEM_ARBITER_FIXED_PRIO_EN -> P0 granted every time, P1 starves.
//  5 P1 write addr MEM_SIZE data 0xFF -> mem_wr_en_o never 1, rsp_err_o=1,
//    rsp_rdata_o=0; prior read of MEM_SIZE-1 unchanged.
//  6 Valid held in ACCESS/RESP -> req_ready_o=0 there; no double accept.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between NUM_PORTS requesters.
// Round-robin grant by default; define DMEM_ARBITER_FIXED_PRIO_EN for fixed lowest-index priority.
module dmem_arbiter #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 192
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_PORTS-1:0]             req_valid_i,
  output logic [NUM_PORTS-1:0]             req_ready_o,
  input  logic [NUM_PORTS-1:0]             req_we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata_i,
  output logic [NUM_PORTS-1:0]             rsp_valid_o,
  output logic [DATA_WIDTH-1:0]            rsp_rdata_o,
  output logic                             rsp_err_o,
  output logic                             mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic [DATA_WIDTH-1:0]            mem_wr_data_o,
  input  logic [DATA_WIDTH-1:0]            mem_rd_data_i
);

  localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t                 state_q;
  logic                   we_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   err_q;
  logic [PORT_W-1:0]      port_q;
  logic [NUM_PORTS-1:0]   rsp_valid_q;

  logic                   grant_found;
  logic [PORT_W-1:0]      grant_idx;
  logic                   in_range;

  // Compare one bit wider than the address so MEM_SIZE == 2**ADDR_WIDTH never wraps.
  assign in_range = ({1'b0, addr_q} < MEM_LIMIT);

`ifdef DMEM_ARBITER_FIXED_PRIO_EN
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!grant_found && req_valid_i[i]) begin
        grant_found = 1'b1;
        grant_idx   = PORT_W'(i);
      end
    end
  end
`else
  logic [PORT_W-1:0] last_q;
  int unsigned       cand;

  // Search starts one past the last granted port and wraps around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      cand = (int'(last_q) + i) % NUM_PORTS;
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = PORT_W'(cand);
      end
    end
  end
`endif

  always_comb begin
    req_ready_o = '0;
    if (state_q == IDLE && grant_found) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      port_q      <= '0;
      rsp_valid_q <= '0;
`ifndef DMEM_ARBITER_FIXED_PRIO_EN
      last_q      <= PORT_W'(NUM_PORTS - 1);
`endif
    end else begin
      rsp_valid_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (grant_found) begin
            we_q    <= req_we_i[grant_idx];
            addr_q  <= req_addr_i[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q <= req_wdata_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            port_q  <= grant_idx;
`ifndef DMEM_ARBITER_FIXED_PRIO_EN
            last_q  <= grant_idx;
`endif
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          rdata_q             <= (!we_q && in_range) ? mem_rd_data_i : '0;
          err_q               <= !in_range;
          rsp_valid_q[port_q] <= 1'b1;
          state_q             <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Write enable is decoded from state so an async reset kills it in the same cycle.
  assign mem_wr_en_o   = (state_q == ACCESS) && we_q && in_range;
  assign mem_addr_o    = addr_q;
  assign mem_wr_data_o = wdata_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;

endmodule
